id_stage_module: RTL and testbench
==================================

ID_STAGE_MODULE -- requirements
Module: id_stage_module

Interface
REQ-001 Parameters: none; widths come from `ADDRESS_LEN (32) and `INSTRUCTION_LEN (32) in Constants.v.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  branch taken in EX; kill the instruction being decoded.
REQ-005 hazard  in  1  RAW hazard detected; insert bubble.
REQ-006 pc_in  in  32  PC+4 from IF pipeline register.
REQ-007 instruction_in  in  32  instruction from IF pipeline register.
REQ-008 status_in  in  4  {N,Z,C,V} from status register.
REQ-009 wb_en_in, wb_dest[3:0], wb_value[31:0]  in  1/4/32  register-file write port from WB.
REQ-010 src1, src2  out  4 each  combinational source register numbers for hazard unit.
REQ-011 two_src  out  1  combinational; instruction reads src2.
REQ-012 pc, val_rn, val_rm  out  32 each  registered.
REQ-013 dest, exe_cmd  out  4 each  registered.
REQ-014 shift_operand[11:0], signed_imm_24[23:0], imm, s, b, mem_r_en, mem_w_en, wb_en  out  registered.

Function
REQ-015 Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_operand[11:0], signed_imm_24[23:0].
REQ-016 Mode 00 exe_cmd map: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; unmapped opcode -> all controls 0.
REQ-017 Mode 00: wb_en=1 except CMP/TST; s=S.
REQ-018 Mode 01: exe_cmd=0010; S=1 -> LDR (mem_r_en=1, wb_en=1); S=0 -> STR (mem_w_en=1, wb_en=0); s=0.
REQ-019 Mode 10: b=1, all other controls 0; mode 11: all controls 0.
REQ-020 Condition check on status_in: EQ..LE per ARM (0000-1101), 1110 AL always true, 1111 false.
REQ-021 Condition false -> exe_cmd, mem_r_en, mem_w_en, wb_en, s, b written as 0 (bubble).
REQ-022 src1=Rn; src2 = Rd when mode 01 with S=0, else shift_operand[3:0]; two_src = ~I | (mode 01 & S=0).
REQ-023 Register file: 15 x 32 (R0-R14), written at rising edge when wb_en_in=1; wb_dest=15 ignored.
REQ-024 Reads combinational; same-cycle write to read address bypasses wb_value; reading R15 returns pc_in.
REQ-025 Pipeline register: flush=1 -> all registered outputs 0 next edge; else hazard=1 -> controls 0, data fields still captured; else capture decode.
REQ-026 flush has priority over hazard; both may be asserted same cycle.
REQ-027 Latency: one cycle from instruction_in to registered outputs.

Reset
REQ-028 rst=1 immediately clears all registered outputs and all 15 registers to 0, independent of clk.
REQ-029 Reset mid-operation discards pending writeback; first post-reset edge behaves per REQ-025.
REQ-030 src1/src2/two_src remain combinational from instruction_in during reset.

Verification
REQ-031 rst pulse between edges -> all outputs 0 at once, R0-R14 read 0.
REQ-032 wb R3=0x0000_00AA, decode ADD R1,R3,R4 (0xE0831004) same cycle -> val_rn=0xAA, exe_cmd=0010, wb_en=1, dest=1.
REQ-033 0x0A000010 (BEQ) with Z=0 -> b=0, all controls 0; with Z=1 -> b=1, signed_imm_24=0x000010.
REQ-034 STR 0xE5812000 -> mem_w_en=1, wb_en=0, src2=2, two_src=1, exe_cmd=0010.
REQ-035 CMP with hazard=1 and flush=1 same cycle -> all outputs 0; hazard alone -> controls 0, pc captured.

Source files
------------

// File: rtl/id_stage_module.sv
// Instruction decode stage: ARM-like field decode, condition check, 15-entry register file
// with write bypass, and the ID/EX pipeline register (flush beats hazard).
module id_stage_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hazard,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic [3:0]  status_in,
    input  logic        wb_en_in,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [31:0] pc,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic [3:0]  dest,
    output logic [3:0]  exe_cmd,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic        imm,
    output logic        s,
    output logic        b,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        wb_en
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Instruction fields
    logic [3:0]  f_cond;
    logic [1:0]  f_mode;
    logic        f_i;
    logic [3:0]  f_opcode;
    logic        f_s;
    logic [3:0]  f_rn;
    logic [3:0]  f_rd;
    logic [11:0] f_shift;
    logic [23:0] f_imm24;

    assign f_cond   = instruction_in[31:28];
    assign f_mode   = instruction_in[27:26];
    assign f_i      = instruction_in[25];
    assign f_opcode = instruction_in[24:21];
    assign f_s      = instruction_in[20];
    assign f_rn     = instruction_in[19:16];
    assign f_rd     = instruction_in[15:12];
    assign f_shift  = instruction_in[11:0];
    assign f_imm24  = instruction_in[23:0];

    logic is_store;
    assign is_store = (f_mode == 2'b01) && !f_s;

    // Stores read Rd as the data to write, so it takes the second read port.
    assign src1    = f_rn;
    assign src2    = is_store ? f_rd : f_shift[3:0];
    assign two_src = !f_i || is_store;

    // Condition evaluation against {N,Z,C,V}
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign flag_n = status_in[3];
    assign flag_z = status_in[2];
    assign flag_c = status_in[1];
    assign flag_v = status_in[0];

    always_comb begin
        cond_pass = 1'b0;
        case (f_cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Control decode; a failed condition turns the instruction into a bubble.
    logic [3:0] dec_exe_cmd;
    logic       dec_mem_r_en;
    logic       dec_mem_w_en;
    logic       dec_wb_en;
    logic       dec_s;
    logic       dec_b;
    logic       alu_mapped;

    always_comb begin
        dec_exe_cmd  = 4'b0000;
        dec_mem_r_en = 1'b0;
        dec_mem_w_en = 1'b0;
        dec_wb_en    = 1'b0;
        dec_s        = 1'b0;
        dec_b        = 1'b0;
        alu_mapped   = 1'b1;
        case (f_mode)
            2'b00: begin
                case (f_opcode)
                    OP_MOV:  begin dec_exe_cmd = EXE_MOV; dec_wb_en = 1'b1; end
                    OP_MVN:  begin dec_exe_cmd = EXE_MVN; dec_wb_en = 1'b1; end
                    OP_ADD:  begin dec_exe_cmd = EXE_ADD; dec_wb_en = 1'b1; end
                    OP_ADC:  begin dec_exe_cmd = EXE_ADC; dec_wb_en = 1'b1; end
                    OP_SUB:  begin dec_exe_cmd = EXE_SUB; dec_wb_en = 1'b1; end
                    OP_SBC:  begin dec_exe_cmd = EXE_SBC; dec_wb_en = 1'b1; end
                    OP_AND:  begin dec_exe_cmd = EXE_AND; dec_wb_en = 1'b1; end
                    OP_ORR:  begin dec_exe_cmd = EXE_ORR; dec_wb_en = 1'b1; end
                    OP_EOR:  begin dec_exe_cmd = EXE_EOR; dec_wb_en = 1'b1; end
                    OP_CMP:  dec_exe_cmd = EXE_SUB;
                    OP_TST:  dec_exe_cmd = EXE_AND;
                    default: alu_mapped  = 1'b0;
                endcase
                dec_s = f_s && alu_mapped;
            end
            2'b01: begin
                dec_exe_cmd = EXE_ADD;
                if (f_s) begin
                    dec_mem_r_en = 1'b1;
                    dec_wb_en    = 1'b1;
                end else begin
                    dec_mem_w_en = 1'b1;
                end
            end
            2'b10: dec_b = 1'b1;
            default: ;
        endcase
        if (!cond_pass) begin
            dec_exe_cmd  = 4'b0000;
            dec_mem_r_en = 1'b0;
            dec_mem_w_en = 1'b0;
            dec_wb_en    = 1'b0;
            dec_s        = 1'b0;
            dec_b        = 1'b0;
        end
    end

    // Register file R0-R14; R15 is the PC and is never stored here.
    logic [31:0] regs [0:14];
    logic [31:0] rd_rn;
    logic [31:0] rd_rm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_en_in && (wb_dest != 4'd15)) begin
            regs[wb_dest] <= wb_value;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees a stale value.
    always_comb begin
        if (src1 == 4'd15) begin
            rd_rn = pc_in;
        end else if (wb_en_in && (wb_dest == src1)) begin
            rd_rn = wb_value;
        end else begin
            rd_rn = regs[src1];
        end
        if (src2 == 4'd15) begin
            rd_rm = pc_in;
        end else if (wb_en_in && (wb_dest == src2)) begin
            rd_rm = wb_value;
        end else begin
            rd_rm = regs[src2];
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            pc            <= 32'd0;
            val_rn        <= 32'd0;
            val_rm        <= 32'd0;
            dest          <= 4'd0;
            exe_cmd       <= 4'd0;
            shift_operand <= 12'd0;
            signed_imm_24 <= 24'd0;
            imm           <= 1'b0;
            s             <= 1'b0;
            b             <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en         <= 1'b0;
        end else begin
            pc            <= pc_in;
            val_rn        <= rd_rn;
            val_rm        <= rd_rm;
            dest          <= f_rd;
            shift_operand <= f_shift;
            signed_imm_24 <= f_imm24;
            imm           <= f_i;
            if (hazard) begin
                exe_cmd  <= 4'd0;
                s        <= 1'b0;
                b        <= 1'b0;
                mem_r_en <= 1'b0;
                mem_w_en <= 1'b0;
                wb_en    <= 1'b0;
            end else begin
                exe_cmd  <= dec_exe_cmd;
                s        <= dec_s;
                b        <= dec_b;
                mem_r_en <= dec_mem_r_en;
                mem_w_en <= dec_mem_w_en;
                wb_en    <= dec_wb_en;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_module.sv
// Directed bench for id_stage_module: decode vector table plus register-file,
// bypass and asynchronous-reset sequences.
module tb_id_stage_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        hazard;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic [3:0]  status_in;
    logic        wb_en_in;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic [3:0]  exe_cmd;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic        imm;
    logic        s;
    logic        b;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;

    int checks   = 0;
    int failures = 0;

    id_stage_module dut (
        .clk(clk), .rst(rst), .flush(flush), .hazard(hazard),
        .pc_in(pc_in), .instruction_in(instruction_in), .status_in(status_in),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .two_src(two_src),
        .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
        .dest(dest), .exe_cmd(exe_cmd),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .imm(imm), .s(s), .b(b),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  status;
        logic        fl;
        logic        hz;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        sf;
        logic        br;
        logic [3:0]  dst;
        logic        im;
        logic [11:0] shf;
        logic [23:0] imm24;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        two;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [145:0] all_regd();
        return {pc, val_rn, val_rm, dest, exe_cmd, shift_operand, signed_imm_24,
                imm, s, b, mem_r_en, mem_w_en, wb_en};
    endfunction

    initial begin
        // instr status fl hz | cmd mr mw wb s b | dest imm shift imm24 | src1 src2 two
        vecs[0]  = '{32'hE0831004, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 12'h004, 24'h831004, 4'h3, 4'h4, 1'b1};
        vecs[1]  = '{32'hE3B02005, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 12'h005, 24'hB02005, 4'h0, 4'h5, 1'b0};
        vecs[2]  = '{32'hE1510002, 4'h0, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 12'h002, 24'h510002, 4'h1, 4'h2, 1'b1};
        vecs[3]  = '{32'hE5812000, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 12'h000, 24'h812000, 4'h1, 4'h2, 1'b1};
        vecs[4]  = '{32'hE5912004, 4'h0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 12'h004, 24'h912004, 4'h1, 4'h4, 1'b1};
        vecs[5]  = '{32'h0A000010, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 12'h010, 24'h000010, 4'h0, 4'h0, 1'b0};
        vecs[6]  = '{32'h0A000010, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 12'h010, 24'h000010, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{32'hE0721003, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 12'h003, 24'h721003, 4'h2, 4'h3, 1'b1};
        vecs[8]  = '{32'hEC123456, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 12'h456, 24'h123456, 4'h2, 4'h6, 1'b1};
        vecs[9]  = '{32'h10831004, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 12'h004, 24'h831004, 4'h3, 4'h4, 1'b1};
        vecs[10] = '{32'hC0831004, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 12'h004, 24'h831004, 4'h3, 4'h4, 1'b1};
        vecs[11] = '{32'hB0465007, 4'h8, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 12'h007, 24'h465007, 4'h6, 4'h7, 1'b1};
        vecs[12] = '{32'hF0831004, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 12'h004, 24'h831004, 4'h3, 4'h4, 1'b1};
        vecs[13] = '{32'hE0831004, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 12'h004, 24'h831004, 4'h3, 4'h4, 1'b1};
        vecs[14] = '{32'hE1510002, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 24'h000000, 4'h1, 4'h2, 1'b1};
        vecs[15] = '{32'hE3E000FF, 4'h0, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 12'h0FF, 24'hE000FF, 4'h0, 4'hF, 1'b0};
        vecs[16] = '{32'h80221003, 4'h2, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 12'h003, 24'h221003, 4'h2, 4'h3, 1'b1};
        vecs[17] = '{32'h91130004, 4'h0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 12'h004, 24'h130004, 4'h3, 4'h4, 1'b1};

        // Reset state; decode-side ports stay live during reset
        rst = 1'b1; flush = 1'b0; hazard = 1'b0; pc_in = 32'h0;
        instruction_in = 32'hE0831004; status_in = 4'h0;
        wb_en_in = 1'b0; wb_dest = 4'h0; wb_value = 32'h0;
        repeat (2) tick();
        check("reset_outputs", all_regd(), '0);
        check("reset_comb_src", {src1, src2, two_src}, {4'h3, 4'h4, 1'b1});
        rst = 1'b0;

        // Fill R0-R14 with distinct values
        for (int k = 0; k < 15; k++) begin
            wb_en_in = 1'b1; wb_dest = 4'(k); wb_value = 32'h1000 + k;
            tick();
        end
        wb_en_in = 1'b0;

        instruction_in = 32'hE085000E; pc_in = 32'h44;
        tick();
        check("rf_read_r5_r14", {val_rn, val_rm}, {32'h1005, 32'h100E});

        // R15 reads the PC; a writeback to 15 must not disturb anything
        wb_en_in = 1'b1; wb_dest = 4'hF; wb_value = 32'hDEAD_BEEF;
        instruction_in = 32'hE08F000F; pc_in = 32'h80;
        tick();
        check("rf_read_r15", {val_rn, val_rm}, {32'h80, 32'h80});
        wb_en_in = 1'b0;

        // Writeback to R3 in the same cycle it is decoded
        wb_en_in = 1'b1; wb_dest = 4'h3; wb_value = 32'h0000_00AA;
        instruction_in = 32'hE0831004; pc_in = 32'h200;
        tick();
        check("bypass_val_rn", {val_rn, val_rm}, {32'hAA, 32'h1004});
        check("bypass_ctrl", {exe_cmd, wb_en, dest, pc}, {4'h2, 1'b1, 4'h1, 32'h200});
        wb_en_in = 1'b0;
        tick();
        check("bypass_stored", val_rn, 32'hAA);

        // Decode table
        for (int i = 0; i < 18; i++) begin
            instruction_in = vecs[i].instr;
            status_in      = vecs[i].status;
            flush          = vecs[i].fl;
            hazard         = vecs[i].hz;
            pc_in          = 32'h300 + 32'(i * 4);
            #1;
            check($sformatf("v%0d_comb", i), {src1, src2, two_src},
                  {vecs[i].s1, vecs[i].s2, vecs[i].two});
            tick();
            check($sformatf("v%0d_ctrl", i), {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b},
                  {vecs[i].cmd, vecs[i].mr, vecs[i].mw, vecs[i].wb, vecs[i].sf, vecs[i].br});
            check($sformatf("v%0d_data", i), {dest, imm, shift_operand, signed_imm_24},
                  {vecs[i].dst, vecs[i].im, vecs[i].shf, vecs[i].imm24});
            check($sformatf("v%0d_pc", i), pc, vecs[i].fl ? 32'h0 : pc_in);
            if (vecs[i].fl) check($sformatf("v%0d_flush_vals", i), {val_rn, val_rm}, '0);
        end
        flush = 1'b0; hazard = 1'b0; status_in = 4'h0;

        // Asynchronous reset pulse between edges with a writeback pending
        wb_en_in = 1'b1; wb_dest = 4'h7; wb_value = 32'h5555_5555;
        rst = 1'b1;
        #2;
        check("async_reset_outputs", all_regd(), '0);
        rst = 1'b0;
        wb_en_in = 1'b0;
        for (int k = 0; k < 15; k++) begin
            instruction_in = 32'hE0800000 | (32'(k) << 16) | 32'(k);
            tick();
            check($sformatf("post_reset_r%0d", k), {val_rn, val_rm}, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
